// File: rtl/ipif_param_bank.sv
// IPIF register bank for IP running on the bus clock. It turns level RdCE/WrCE into
// one-shot accesses and supports RW, RO, PULSE and STICKY registers with an optional shadow stage.
module ipif_param_bank #(
    parameter int                 C_S_AXI_DATA_WIDTH = 32,
    parameter int                 N_REG              = 4,
    parameter logic [2*N_REG-1:0] REG_MODE           = '0,
    parameter int                 PULSE_LEN          = 1,
    parameter bit                 SHADOW             = 1'b0
) (
    input  logic                                S_AXI_ACLK,
    input  logic                                S_AXI_ARESETN,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       Bus2IP_Data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     Bus2IP_BE,
    input  logic [N_REG-1:0]                    Bus2IP_RdCE,
    input  logic [N_REG-1:0]                    Bus2IP_WrCE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       IP2Bus_Data,
    output logic                                IP2Bus_RdAck,
    output logic                                IP2Bus_WrAck,
    output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] params_to_IP,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] params_from_IP,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] events_from_IP,
    input  logic                                commit,
    output logic [N_REG-1:0]                    wr_strobe_to_IP,
    output logic [N_REG-1:0]                    rd_strobe_to_IP
);

    localparam int         W           = C_S_AXI_DATA_WIDTH;
    localparam int         NB          = W / 8;
    localparam logic [1:0] MODE_RW     = 2'd0;
    localparam logic [1:0] MODE_RO     = 2'd1;
    localparam logic [1:0] MODE_PULSE  = 2'd2;
    localparam logic [1:0] MODE_STICKY = 2'd3;
    localparam logic [7:0] PULSE_INIT  = 8'(PULSE_LEN);
    localparam logic [N_REG-1:0] ONE   = 1;

    function automatic logic [1:0] mode_of(input int idx);
        return REG_MODE[2*idx +: 2];
    endfunction

    logic [N_REG-1:0] wr_ce_q, rd_ce_q;
    logic [N_REG-1:0] wr_edge, rd_edge, wr_sel, rd_sel;
    logic [W-1:0]     be_mask;
    logic [W-1:0]     data_q [N_REG];
    logic [W-1:0]     data_d [N_REG];
    logic [W-1:0]     act_q  [N_REG];
    logic [W-1:0]     act_d  [N_REG];
    logic [7:0]       cnt_q  [N_REG];
    logic [7:0]       cnt_d  [N_REG];
    logic [W-1:0]     reg_val[N_REG];
    logic [W-1:0]     rd_mux;
    logic [W-1:0]     rd_data_q;
    logic             wr_ack_q, rd_ack_q;
    logic [N_REG-1:0] wr_stb_q, rd_stb_q;

    // Bus handshake: a CE rising edge is the request; the bank answers with exactly one
    // single-cycle ack (plus strobe) on the next cycle, and needs no CE deassertion to accept it.
    // Simultaneous rising bits are resolved to the lowest index by isolating the lowest set bit.
    assign wr_edge = Bus2IP_WrCE & ~wr_ce_q;
    assign rd_edge = Bus2IP_RdCE & ~rd_ce_q;
    assign wr_sel  = wr_edge & (~wr_edge + ONE);
    assign rd_sel  = rd_edge & (~rd_edge + ONE);

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < NB; b++) begin
            be_mask[8*b +: 8] = {8{Bus2IP_BE[b]}};
        end
    end

    always_comb begin
        for (int i = 0; i < N_REG; i++) begin
            data_d[i] = data_q[i];
            cnt_d[i]  = cnt_q[i];
            case (mode_of(i))
                MODE_RW: begin
                    if (wr_sel[i]) begin
                        data_d[i] = (data_q[i] & ~be_mask) | (Bus2IP_Data & be_mask);
                    end
                end
                MODE_PULSE: begin
                    if (wr_sel[i]) begin
                        data_d[i] = Bus2IP_Data & be_mask;
                        cnt_d[i]  = PULSE_INIT;
                    end else if (cnt_q[i] != 8'd0) begin
                        cnt_d[i] = cnt_q[i] - 8'd1;
                        if (cnt_q[i] == 8'd1) begin
                            data_d[i] = '0;
                        end
                    end
                end
                MODE_STICKY: begin
                    // Events are OR-ed in after the clear so a coincident set wins.
                    data_d[i] = (data_q[i] & ~({W{wr_sel[i]}} & Bus2IP_Data & be_mask))
                              | events_from_IP[i*W +: W];
                end
                default: data_d[i] = '0;
            endcase
            act_d[i] = (SHADOW && (mode_of(i) == MODE_RW) && commit) ? data_d[i] : act_q[i];
        end
    end

    always_comb begin
        rd_mux       = '0;
        params_to_IP = '0;
        for (int i = 0; i < N_REG; i++) begin
            reg_val[i] = (mode_of(i) == MODE_RO) ? params_from_IP[i*W +: W] : data_q[i];
            if (rd_sel[i]) begin
                rd_mux = rd_mux | reg_val[i];
            end
            params_to_IP[i*W +: W] = (SHADOW && (mode_of(i) == MODE_RW)) ? act_q[i] : reg_val[i];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_ce_q   <= '0;
            rd_ce_q   <= '0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            wr_stb_q  <= '0;
            rd_stb_q  <= '0;
            rd_data_q <= '0;
            for (int i = 0; i < N_REG; i++) begin
                data_q[i] <= '0;
                act_q[i]  <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            wr_ce_q  <= Bus2IP_WrCE;
            rd_ce_q  <= Bus2IP_RdCE;
            wr_ack_q <= |wr_sel;
            rd_ack_q <= |rd_sel;
            wr_stb_q <= wr_sel;
            rd_stb_q <= rd_sel;
            if (|rd_sel) begin
                rd_data_q <= rd_mux;
            end
            for (int i = 0; i < N_REG; i++) begin
                data_q[i] <= data_d[i];
                act_q[i]  <= act_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    assign IP2Bus_Data     = rd_data_q;
    assign IP2Bus_RdAck    = rd_ack_q;
    assign IP2Bus_WrAck    = wr_ack_q;
    assign wr_strobe_to_IP = wr_stb_q;
    assign rd_strobe_to_IP = rd_stb_q;

endmodule

// File: tb/tb_ipif_param_bank.sv
// Directed bench for ipif_param_bank: a direct instance and a shadowed instance share one bus;
// acks are checked by a monitor against expected queues, parameter outputs by direct checks.
module tb_ipif_param_bank;

    localparam int W  = 32;
    localparam int N  = 5;
    localparam int PL = 3;
    // reg0 RW, reg1 RW, reg2 PULSE, reg3 STICKY, reg4 RO
    localparam logic [2*N-1:0] MODES = 10'h1E0;
    localparam logic [W-1:0] RO_VAL  = 32'hCAFE_F00D;
    localparam logic [W-1:0] RO_VAL2 = 32'h1357_9BDF;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   bus_data;
    logic [W/8-1:0] bus_be;
    logic [N-1:0]   rd_ce, wr_ce;
    logic [N*W-1:0] p_from, ev;
    logic           commit;

    logic [W-1:0]   rdata, s_rdata;
    logic           rd_ack, wr_ack, s_rd_ack, s_wr_ack;
    logic [N*W-1:0] p_to, s_p_to;
    logic [N-1:0]   wstb, rstb, s_wstb, s_rstb;

    int n_vec  = 0;
    int n_miss = 0;

    logic [W-1:0] rd_exp_q[$];
    logic [N-1:0] rs_exp_q[$];
    logic [N-1:0] wr_exp_q[$];
    logic [W-1:0] mon_rd;
    logic [N-1:0] mon_rs, mon_ws;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    ipif_param_bank #(
        .C_S_AXI_DATA_WIDTH(W), .N_REG(N), .REG_MODE(MODES), .PULSE_LEN(PL), .SHADOW(1'b0)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .Bus2IP_Data(bus_data), .Bus2IP_BE(bus_be),
        .Bus2IP_RdCE(rd_ce), .Bus2IP_WrCE(wr_ce),
        .IP2Bus_Data(rdata), .IP2Bus_RdAck(rd_ack), .IP2Bus_WrAck(wr_ack),
        .params_to_IP(p_to), .params_from_IP(p_from), .events_from_IP(ev),
        .commit(commit), .wr_strobe_to_IP(wstb), .rd_strobe_to_IP(rstb)
    );

    ipif_param_bank #(
        .C_S_AXI_DATA_WIDTH(W), .N_REG(N), .REG_MODE(MODES), .PULSE_LEN(PL), .SHADOW(1'b1)
    ) dut_s (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .Bus2IP_Data(bus_data), .Bus2IP_BE(bus_be),
        .Bus2IP_RdCE(rd_ce), .Bus2IP_WrCE(wr_ce),
        .IP2Bus_Data(s_rdata), .IP2Bus_RdAck(s_rd_ack), .IP2Bus_WrAck(s_wr_ack),
        .params_to_IP(s_p_to), .params_from_IP(p_from), .events_from_IP(ev),
        .commit(commit), .wr_strobe_to_IP(s_wstb), .rd_strobe_to_IP(s_rstb)
    );

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack consumes one expected entry.
    always @(negedge clk) begin
        if (wr_ack || s_wr_ack) begin
            if (wr_exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL wr_ack_unexpected: got ack with strobe %h, expected no ack", wstb);
            end else begin
                mon_ws = wr_exp_q.pop_front();
                check("wr_strobe", W'(wstb), W'(mon_ws));
                check("wr_strobe_shadow", W'(s_wstb), W'(mon_ws));
            end
        end
        if (rd_ack || s_rd_ack) begin
            if (rd_exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rd_ack_unexpected: got ack with data %h, expected no ack", rdata);
            end else begin
                mon_rd = rd_exp_q.pop_front();
                mon_rs = rs_exp_q.pop_front();
                check("rd_data", rdata, mon_rd);
                check("rd_data_shadow", s_rdata, mon_rd);
                check("rd_strobe", W'(rstb), W'(mon_rs));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [N-1:0] oh(input int idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr_begin(input logic [N-1:0] ce, input logic [W-1:0] d,
                            input logic [W/8-1:0] be, input logic [N-1:0] exp_stb);
        wr_ce    = ce;
        bus_data = d;
        bus_be   = be;
        wr_exp_q.push_back(exp_stb);
    endtask

    task automatic wr_end();
        wr_ce = '0;
    endtask

    task automatic write_reg(input int idx, input logic [W-1:0] d, input logic [W/8-1:0] be);
        wr_begin(oh(idx), d, be, oh(idx));
        step();
        wr_end();
        step();
    endtask

    // Read with RdCE held two cycles; only one ack may result.
    task automatic read_reg(input int idx, input logic [W-1:0] exp);
        rd_ce = oh(idx);
        rd_exp_q.push_back(exp);
        rs_exp_q.push_back(oh(idx));
        step();
        step();
        rd_ce = '0;
        step();
    endtask

    function automatic logic [W-1:0] slot(input logic [N*W-1:0] v, input int idx);
        return v[idx*W +: W];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bus_data = '1;
        bus_be   = '1;
        rd_ce    = '1;
        wr_ce    = '1;
        p_from   = {N{RO_VAL}};
        ev       = '1;
        commit   = 1'b1;
        repeat (3) step();
        check("rst_rdata", rdata, '0);
        check("rst_acks", W'({rd_ack, wr_ack, s_rd_ack, s_wr_ack}), '0);
        check("rst_strobes", W'({rstb, wstb, s_rstb, s_wstb}), '0);
        for (int i = 0; i < N - 1; i++) begin
            check("rst_param", slot(p_to, i), '0);
            check("rst_param_shadow", slot(s_p_to, i), '0);
        end
        check("rst_ro_mirror", slot(p_to, 4), RO_VAL);

        // Release with WrCE[0] held five cycles: one ack only.
        rd_ce  = '0;
        ev     = '0;
        commit = 1'b0;
        wr_begin(oh(0), 32'hA5A5_A5A5, 4'hF, oh(0));
        rst_n = 1'b1;
        step();
        check("first_wr_param", slot(p_to, 0), 32'hA5A5_A5A5);
        check("first_wr_shadow_hold", slot(s_p_to, 0), '0);
        repeat (4) step();
        wr_end();
        step();
        read_reg(0, 32'hA5A5_A5A5);

        // Byte-enable write.
        write_reg(1, 32'h1122_3344, 4'hF);
        wr_begin(oh(1), 32'hFFFF_FFFF, 4'h5, oh(1));
        step();
        check("be_param", slot(p_to, 1), 32'h11FF_33FF);
        wr_end();
        step();
        read_reg(1, 32'h11FF_33FF);

        // Back-to-back accesses on different registers.
        wr_begin(oh(0), 32'h0101_0101, 4'hF, oh(0));
        step();
        wr_begin(oh(1), 32'h0202_0202, 4'hF, oh(1));
        step();
        wr_end();
        step();
        check("b2b_reg0", slot(p_to, 0), 32'h0101_0101);
        check("b2b_reg1", slot(p_to, 1), 32'h0202_0202);

        // PULSE: three cycles high, then clear.
        wr_begin(oh(2), 32'h3, 4'hF, oh(2));
        step();
        check("pulse_c1", slot(p_to, 2), 32'h3);
        check("pulse_c1_shadow", slot(s_p_to, 2), 32'h3);
        wr_end();
        step();
        check("pulse_c2", slot(p_to, 2), 32'h3);
        step();
        check("pulse_c3", slot(p_to, 2), 32'h3);
        step();
        check("pulse_end", slot(p_to, 2), '0);

        // PULSE rewrite at cycle 2 restarts the count.
        wr_begin(oh(2), 32'h3, 4'hF, oh(2));
        step();
        check("pulse_rw_c1", slot(p_to, 2), 32'h3);
        wr_end();
        step();
        check("pulse_rw_c2", slot(p_to, 2), 32'h3);
        wr_begin(oh(2), 32'h4, 4'hF, oh(2));
        step();
        check("pulse_new_c1", slot(p_to, 2), 32'h4);
        wr_end();
        step();
        check("pulse_new_c2", slot(p_to, 2), 32'h4);
        step();
        check("pulse_new_c3", slot(p_to, 2), 32'h4);
        step();
        check("pulse_new_end", slot(p_to, 2), '0);

        // PULSE with partial byte enables clears the other bytes.
        wr_begin(oh(2), 32'hFFFF_FFFF, 4'h2, oh(2));
        step();
        check("pulse_be", slot(p_to, 2), 32'h0000_FF00);
        wr_end();
        repeat (3) step();
        check("pulse_be_end", slot(p_to, 2), '0);
        read_reg(2, '0);

        // STICKY.
        ev[3*W +: W] = 32'h80;
        step();
        ev = '0;
        check("sticky_set", slot(p_to, 3), 32'h80);
        read_reg(3, 32'h80);
        wr_begin(oh(3), 32'h80, 4'hE, oh(3));
        step();
        check("sticky_be_off", slot(p_to, 3), 32'h80);
        wr_end();
        step();
        ev[3*W +: W] = 32'h80;
        wr_begin(oh(3), 32'h80, 4'hF, oh(3));
        step();
        ev = '0;
        check("sticky_set_wins", slot(p_to, 3), 32'h80);
        wr_end();
        step();
        wr_begin(oh(3), 32'h80, 4'hF, oh(3));
        step();
        check("sticky_clear", slot(p_to, 3), '0);
        wr_end();
        step();
        ev[3*W +: W] = 32'h0001_0001;
        step();
        ev = '0;
        write_reg(3, 32'h1, 4'hF);
        read_reg(3, 32'h0001_0000);

        // RO: combinational mirror, writes acked but ignored.
        p_from[4*W +: W] = RO_VAL2;
        #1;
        check("ro_mirror", slot(p_to, 4), RO_VAL2);
        read_reg(4, RO_VAL2);
        write_reg(4, 32'hFFFF_FFFF, 4'hF);
        read_reg(4, RO_VAL2);

        // SHADOW staging and commit.
        wr_begin(oh(0), 32'hDEAD, 4'hF, oh(0));
        step();
        check("shadow_hold", slot(s_p_to, 0), '0);
        check("direct_dead", slot(p_to, 0), 32'hDEAD);
        wr_end();
        step();
        read_reg(0, 32'hDEAD);
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("shadow_commit0", slot(s_p_to, 0), 32'hDEAD);
        check("shadow_commit1", slot(s_p_to, 1), 32'h0202_0202);
        wr_begin(oh(0), 32'hBEEF, 4'hF, oh(0));
        commit = 1'b1;
        step();
        commit = 1'b0;
        check("shadow_commit_wr", slot(s_p_to, 0), 32'hBEEF);
        wr_end();
        step();

        // Simultaneous rising WrCE[2] and WrCE[0].
        wr_begin(5'b00101, 32'h77, 4'hF, oh(0));
        step();
        check("multi_reg0", slot(p_to, 0), 32'h77);
        check("multi_reg2", slot(p_to, 2), '0);
        wr_end();
        step();
        check("multi_reg2_after", slot(p_to, 2), '0);

        // Reset right after the edge drops the access.
        wr_ce    = oh(1);
        bus_data = 32'h5555_5555;
        bus_be   = 4'hF;
        @(posedge clk);
        #1 rst_n = 1'b0;
        step();
        check("rst_drop_ack", W'({wr_ack, s_wr_ack}), '0);
        check("rst_drop_reg1", slot(p_to, 1), '0);
        wr_ce = '0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        read_reg(0, '0);

        repeat (3) step();
        check("wr_queue_drained", W'(wr_exp_q.size()), '0);
        check("rd_queue_drained", W'(rd_exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
